stp_count_mod: RTL and testbench
================================

# stp_count_mod

Parametrised modulo-N time-field counter for the stop-watch/timer datapath: the generalised successor to the fixed 24-hour counter. One instance serves seconds, minutes or hours. It counts up or down on single-cycle pulses, supports hold, clear and preset load, and emits wrap carry/borrow pulses for cascading. It also provides a BCD display value, with an optional 12-hour view for the hour field.

## Interface
- `MODULUS`, default 24: count range 0..MODULUS-1; legal range 2..99.
- `WIDTH`, default 8: binary value width; must satisfy 2^WIDTH >= MODULUS.
- `HOUR_MODE`, default 1: 1 enables the 12-hour view logic; 0 ties `pm` to 0 and `disp_val` to `value`.
- `CLK`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clear`  in  1: synchronous clear to 0.
- `hold`  in  1: freezes `value`; count pulses are ignored, not queued.
- `load`  in  1: single-cycle preset strobe.
- `load_val`  in  WIDTH: preset value.
- `count_up`  in  1: single-cycle increment request.
- `count_dn`  in  1: single-cycle decrement request.
- `mode_12h`  in  1: selects the 12-hour view; has effect only when HOUR_MODE=1.
- `value`  out  WIDTH: registered binary count.
- `carry`  out  1: one-cycle pulse on an up-wrap.
- `borrow`  out  1: one-cycle pulse on a down-wrap.
- `load_err`  out  1: one-cycle pulse when `load_val` >= MODULUS.
- `disp_val`  out  WIDTH: combinational display value derived from registered `value`.
- `disp_bcd`  out  8: `disp_val` as two BCD digits, tens in [7:4] and units in [3:0].
- `pm`  out  1: 1 when `value` >= 12; only meaningful when HOUR_MODE=1.

## Operation
- Priority per cycle, highest first:
  - `rst`: `value`=0, all pulses low.
  - `clear`: `value`=0, pulses low.
  - `load`: takes effect regardless of `hold`.
    - If `load_val` < MODULUS, `value`=`load_val`.
    - Otherwise `value`=MODULUS-1 and `load_err`=1.
  - `hold`: `value` unchanged.
  - Count: evaluated only when none of the above is active.
- Count rules:
  - `count_up` && `count_dn` together: no change, no pulse.
  - Up at MODULUS-1 → 0 with `carry`=1; otherwise +1.
  - Down at 0 → MODULUS-1 with `borrow`=1; otherwise -1.
- `value` never leaves 0..MODULUS-1.
- Arithmetic is WIDTH-bit unsigned. The wrap compare uses the MODULUS-1 constant; no overflow path exists.
- 12-hour view, when HOUR_MODE=1 and `mode_12h`=1:
  - 0 → 12.
  - 1..12 → unchanged.
  - 13..23 → `value`-12.
- Otherwise `disp_val`=`value`.
- `mode_12h` affects display only; it never alters `value`.
- `disp_bcd`: tens = `disp_val`/10, units = `disp_val`%10. Combinational.

## Timing
- Reset values: `value`=0, `carry`=0, `borrow`=0, `load_err`=0.
- `value`, `carry`, `borrow` and `load_err` are registered and update on the same edge. A pulse is high for exactly the one cycle in which the new `value` is first visible.
- Latency:
  - Count request to `value` change: 1 cycle.
  - `value` to `disp_val`/`disp_bcd`/`pm`: 0 cycles, combinational.
- Cascading: the next field's `count_up` is this `carry`, so ripple costs 1 cycle per stage. Back-to-back pulses every cycle are supported.
- `rst` or `clear` in the same cycle as a wrap suppresses `carry`/`borrow`.
- `load` in the same cycle as a count: the load wins and the count is dropped.

## Structure
- Shared package `stp_pkg`:
  - Field moduli constants: `STP_MOD_SEC`=60, `STP_MOD_MIN`=60, `STP_MOD_HR`=24.
  - `STP_FIELD_W`=8.
- One sub-module, `stp_bin2bcd`: combinational 0..99 binary to two-digit BCD converter, reused by the display mux.
- Elaboration-time parameter checks:
  - MODULUS is in range.
  - 2^WIDTH >= MODULUS.
  - HOUR_MODE=1 requires MODULUS=24.

## Test plan
- Reset/count, MODULUS=24:
  - Pulse `rst`, then 24 `count_up` pulses.
  - `value` goes 0..23 then 0.
  - `carry` is high only on the 0 cycle.
  - `disp_bcd`=8'h23 at 23.
- Down wrap, MODULUS=60:
  - From 0, one `count_dn`.
  - `value`=59, `borrow`=1 for 1 cycle, `disp_bcd`=8'h59.
- Priority:
  - `hold`=1 with `count_up`: `value` unchanged.
  - `load`=1, `load_val`=7 with `hold`=1 and `count_up`: `value`=7.
  - `count_up` && `count_dn` at 5: stays 5, no pulse.
- Bad load, MODULUS=24: `load_val`=30 → `value`=23, `load_err`=1 for 1 cycle.
- 12-hour view, `mode_12h`=1:
  - `value`=0 → `disp_bcd`=8'h12, `pm`=0.
  - 13 → 8'h01, `pm`=1.
  - 23 → 8'h11, `pm`=1.
- Cascade: sec→min→hr chain loaded to 23:59:59, then one `count_up` → 00:00:00 after ripple, with hour `carry` pulsing once.

Source files
------------

// File: rtl/stp_pkg.sv
// Shared constants and helpers for the stop-watch/timer time-field datapath.
package stp_pkg;

   localparam int STP_MOD_SEC = 60;
   localparam int STP_MOD_MIN = 60;
   localparam int STP_MOD_HR  = 24;
   localparam int STP_FIELD_W = 8;
   localparam int STP_HR_HALF = 12;

   // Two-digit BCD of a 0..99 binary value: tens in [7:4], units in [3:0].
   function automatic logic [7:0] stp_to_bcd(input logic [6:0] bin);
      return {4'(bin / 7'd10), 4'(bin % 7'd10)};
   endfunction

endpackage

// File: rtl/stp_count_mod_if.sv
// Control/status bundle for one modulo-N time-field counter.
interface stp_count_mod_if #(
   parameter int WIDTH = 8
);
   logic             clear;
   logic             hold;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             count_up;
   logic             count_dn;
   logic             mode_12h;
   logic [WIDTH-1:0] value;
   logic             carry;
   logic             borrow;
   logic             load_err;
   logic [WIDTH-1:0] disp_val;
   logic [7:0]       disp_bcd;
   logic             pm;

   modport master (
      output clear, hold, load, load_val, count_up, count_dn, mode_12h,
      input  value, carry, borrow, load_err, disp_val, disp_bcd, pm
   );

   modport slave (
      input  clear, hold, load, load_val, count_up, count_dn, mode_12h,
      output value, carry, borrow, load_err, disp_val, disp_bcd, pm
   );
endinterface

// File: rtl/stp_bin2bcd.sv
// Combinational 0..99 binary to two-digit BCD converter for the display path.
module stp_bin2bcd
   import stp_pkg::*;
#(
   parameter int IN_W = 8
) (
   input  logic [IN_W-1:0] bin,
   output logic [7:0]      bcd
);

   assign bcd = stp_to_bcd(7'(bin));

endmodule

// File: rtl/stp_count_mod.sv
// Modulo-N up/down time-field counter with hold/clear/preset, wrap pulses for
// cascading, and a BCD display value with an optional 12-hour view.
module stp_count_mod
   import stp_pkg::*;
#(
   parameter int MODULUS   = STP_MOD_HR,
   parameter int WIDTH     = STP_FIELD_W,
   parameter int HOUR_MODE = 1
) (
   input logic           CLK,
   input logic           rst,
   stp_count_mod_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] HALF = WIDTH'(STP_HR_HALF);

   if (MODULUS < 2 || MODULUS > 99) begin : g_bad_modulus
      $error("stp_count_mod: MODULUS must be within 2..99");
   end
   if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_width
      $error("stp_count_mod: WIDTH too narrow for MODULUS");
   end
   if (HOUR_MODE == 1 && MODULUS != 24) begin : g_bad_hour
      $error("stp_count_mod: HOUR_MODE=1 requires MODULUS=24");
   end

   logic [WIDTH-1:0] value_q;
   logic             carry_q;
   logic             borrow_q;
   logic             load_err_q;
   logic [WIDTH-1:0] disp_val;
   logic             pm;

   // Pulses default low every cycle so each lasts exactly one cycle.
   always_ff @(posedge CLK) begin
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      if (rst || bus.clear) begin
         value_q <= '0;
      end else if (bus.load) begin
         if (bus.load_val > MAX) begin
            value_q    <= MAX;
            load_err_q <= 1'b1;
         end else begin
            value_q <= bus.load_val;
         end
      end else if (!bus.hold && (bus.count_up != bus.count_dn)) begin
         if (bus.count_up) begin
            if (value_q == MAX) begin
               value_q <= '0;
               carry_q <= 1'b1;
            end else begin
               value_q <= value_q + WIDTH'(1);
            end
         end else begin
            if (value_q == '0) begin
               value_q  <= MAX;
               borrow_q <= 1'b1;
            end else begin
               value_q <= value_q - WIDTH'(1);
            end
         end
      end
   end

   // 12-hour view: 0 shows as 12, 13..23 fold down by 12.
   always_comb begin
      disp_val = value_q;
      pm       = 1'b0;
      if (HOUR_MODE == 1) begin
         pm = (value_q >= HALF);
         if (bus.mode_12h) begin
            if (value_q == '0)
               disp_val = HALF;
            else if (value_q > HALF)
               disp_val = value_q - HALF;
         end
      end
   end

   stp_bin2bcd #(.IN_W(WIDTH)) u_bcd (
      .bin (disp_val),
      .bcd (bus.disp_bcd)
   );

   assign bus.value    = value_q;
   assign bus.carry    = carry_q;
   assign bus.borrow   = borrow_q;
   assign bus.load_err = load_err_q;
   assign bus.disp_val = disp_val;
   assign bus.pm       = pm;

endmodule

// File: tb/tb_stp_count_mod.sv
// Self-checking bench for stp_count_mod: directed scenarios plus randomized
// traffic against a modular-arithmetic reference model.
module tb_stp_count_mod;

   logic CLK;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   stp_count_mod_if #(.WIDTH(8)) if24 (), if60 (), ifs (), ifm (), ifh ();

   stp_count_mod #(.MODULUS(24), .WIDTH(8), .HOUR_MODE(1)) u24 (.CLK(CLK), .rst(rst), .bus(if24));
   stp_count_mod #(.MODULUS(60), .WIDTH(8), .HOUR_MODE(0)) u60 (.CLK(CLK), .rst(rst), .bus(if60));
   stp_count_mod #(.MODULUS(60), .WIDTH(8), .HOUR_MODE(0)) u_sec (.CLK(CLK), .rst(rst), .bus(ifs));
   stp_count_mod #(.MODULUS(60), .WIDTH(8), .HOUR_MODE(0)) u_min (.CLK(CLK), .rst(rst), .bus(ifm));
   stp_count_mod #(.MODULUS(24), .WIDTH(8), .HOUR_MODE(1)) u_hr (.CLK(CLK), .rst(rst), .bus(ifh));

   assign ifm.count_up = ifs.carry;
   assign ifh.count_up = ifm.carry;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Display reference: 12-hour fold is "hour mod 12, with 0 shown as 12".
   function automatic logic [7:0] exp_bcd(input int v, input bit h12);
      int d;
      d = v;
      if (h12) d = (v % 12 == 0) ? 12 : v % 12;
      return {4'(d / 10), 4'(d % 10)};
   endfunction

   task automatic test_reset();
      rst = 1'b1; if24.count_up = 1'b1; if60.count_dn = 1'b1;
      tick();
      if24.count_up = 1'b0; if60.count_dn = 1'b0;
      n_tests++; if (if24.value !== 8'd0) begin n_fail++; $display("FAIL rst_value24 got=%0d exp=0", if24.value); end
      n_tests++; if (if60.value !== 8'd0) begin n_fail++; $display("FAIL rst_value60 got=%0d exp=0", if60.value); end
      n_tests++; if ({if24.carry, if24.borrow, if24.load_err} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses24 got=%b exp=000", {if24.carry, if24.borrow, if24.load_err}); end
      n_tests++; if ({if60.carry, if60.borrow, if60.load_err} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses60 got=%b exp=000", {if60.carry, if60.borrow, if60.load_err}); end
      rst = 1'b0;
   endtask

   task automatic test_count_up();
      for (int i = 1; i <= 24; i++) begin
         if24.count_up = 1'b1;
         tick();
         if24.count_up = 1'b0;
         n_tests++; if (if24.value !== 8'(i % 24)) begin n_fail++; $display("FAIL up_value step=%0d got=%0d exp=%0d", i, if24.value, i % 24); end
         n_tests++; if (if24.carry !== (i == 24)) begin n_fail++; $display("FAIL up_carry step=%0d got=%b exp=%b", i, if24.carry, (i == 24)); end
         if (i == 23) begin
            n_tests++; if (if24.disp_bcd !== 8'h23) begin n_fail++; $display("FAIL up_bcd23 got=%h exp=23", if24.disp_bcd); end
         end
      end
      tick();
      n_tests++; if (if24.carry !== 1'b0) begin n_fail++; $display("FAIL up_carry_drop got=%b exp=0", if24.carry); end
   endtask

   task automatic test_down_wrap();
      if60.count_dn = 1'b1;
      tick();
      if60.count_dn = 1'b0;
      n_tests++; if (if60.value !== 8'd59) begin n_fail++; $display("FAIL dn_value got=%0d exp=59", if60.value); end
      n_tests++; if (if60.borrow !== 1'b1) begin n_fail++; $display("FAIL dn_borrow got=%b exp=1", if60.borrow); end
      n_tests++; if (if60.disp_bcd !== 8'h59) begin n_fail++; $display("FAIL dn_bcd got=%h exp=59", if60.disp_bcd); end
      n_tests++; if (if60.pm !== 1'b0) begin n_fail++; $display("FAIL dn_pm got=%b exp=0", if60.pm); end
      tick();
      n_tests++; if (if60.borrow !== 1'b0 || if60.value !== 8'd59) begin n_fail++; $display("FAIL dn_hold_after got=%0d/%b exp=59/0", if60.value, if60.borrow); end
   endtask

   task automatic test_priority();
      // hold blocks a count
      if24.hold = 1'b1; if24.count_up = 1'b1;
      tick();
      n_tests++; if (if24.value !== 8'd0) begin n_fail++; $display("FAIL pri_hold got=%0d exp=0", if24.value); end
      // load beats hold and count
      if24.load = 1'b1; if24.load_val = 8'd7;
      tick();
      n_tests++; if (if24.value !== 8'd7) begin n_fail++; $display("FAIL pri_load_hold got=%0d exp=7", if24.value); end
      if24.hold = 1'b0; if24.load_val = 8'd5; if24.count_up = 1'b0; if24.count_dn = 1'b1;
      tick();
      n_tests++; if (if24.value !== 8'd5) begin n_fail++; $display("FAIL pri_load_dn got=%0d exp=5", if24.value); end
      // simultaneous up and down cancel
      if24.load = 1'b0; if24.count_up = 1'b1; if24.count_dn = 1'b1;
      tick();
      n_tests++; if (if24.value !== 8'd5 || if24.carry !== 1'b0 || if24.borrow !== 1'b0) begin n_fail++; $display("FAIL pri_updn got=%0d c=%b b=%b exp=5 0 0", if24.value, if24.carry, if24.borrow); end
      // clear beats load
      if24.count_dn = 1'b0; if24.count_up = 1'b0; if24.clear = 1'b1; if24.load = 1'b1; if24.load_val = 8'd9;
      tick();
      n_tests++; if (if24.value !== 8'd0 || if24.load_err !== 1'b0) begin n_fail++; $display("FAIL pri_clear_load got=%0d e=%b exp=0 0", if24.value, if24.load_err); end
      // clear at the wrap point suppresses carry
      if24.clear = 1'b0; if24.load_val = 8'd23;
      tick();
      if24.load = 1'b0; if24.clear = 1'b1; if24.count_up = 1'b1;
      tick();
      n_tests++; if (if24.value !== 8'd0 || if24.carry !== 1'b0) begin n_fail++; $display("FAIL pri_clear_wrap got=%0d c=%b exp=0 0", if24.value, if24.carry); end
      // reset at the wrap point suppresses borrow
      if24.clear = 1'b0; if24.count_up = 1'b0; if24.count_dn = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; if24.count_dn = 1'b0;
      n_tests++; if (if24.value !== 8'd0 || if24.borrow !== 1'b0) begin n_fail++; $display("FAIL pri_rst_wrap got=%0d b=%b exp=0 0", if24.value, if24.borrow); end
   endtask

   task automatic test_bad_load();
      logic [7:0] vals [3] = '{8'd30, 8'd24, 8'd23};
      for (int i = 0; i < 3; i++) begin
         if24.load = 1'b1; if24.load_val = vals[i];
         tick();
         if24.load = 1'b0;
         n_tests++; if (if24.value !== 8'd23) begin n_fail++; $display("FAIL bad_load_value lv=%0d got=%0d exp=23", vals[i], if24.value); end
         n_tests++; if (if24.load_err !== (vals[i] >= 8'd24)) begin n_fail++; $display("FAIL bad_load_err lv=%0d got=%b exp=%b", vals[i], if24.load_err, (vals[i] >= 8'd24)); end
         tick();
         n_tests++; if (if24.load_err !== 1'b0) begin n_fail++; $display("FAIL bad_load_drop lv=%0d got=%b exp=0", vals[i], if24.load_err); end
      end
   endtask

   task automatic test_12h();
      int hrs [6] = '{0, 1, 12, 13, 23, 11};
      if24.mode_12h = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if24.load = 1'b1; if24.load_val = 8'(hrs[i]);
         tick();
         if24.load = 1'b0;
         n_tests++; if (if24.disp_bcd !== exp_bcd(hrs[i], 1'b1)) begin n_fail++; $display("FAIL h12_bcd v=%0d got=%h exp=%h", hrs[i], if24.disp_bcd, exp_bcd(hrs[i], 1'b1)); end
         n_tests++; if (if24.pm !== (hrs[i] >= 12)) begin n_fail++; $display("FAIL h12_pm v=%0d got=%b exp=%b", hrs[i], if24.pm, (hrs[i] >= 12)); end
         n_tests++; if (if24.value !== 8'(hrs[i])) begin n_fail++; $display("FAIL h12_value v=%0d got=%0d", hrs[i], if24.value); end
      end
      if24.mode_12h = 1'b0;
      #1;
      n_tests++; if (if24.disp_bcd !== 8'h11) begin n_fail++; $display("FAIL h24_bcd got=%h exp=11", if24.disp_bcd); end
   endtask

   task automatic test_cascade();
      int hc = 0;
      ifs.load = 1'b1; ifs.load_val = 8'd59;
      ifm.load = 1'b1; ifm.load_val = 8'd59;
      ifh.load = 1'b1; ifh.load_val = 8'd23;
      tick();
      ifs.load = 1'b0; ifm.load = 1'b0; ifh.load = 1'b0;
      n_tests++; if ({ifh.value, ifm.value, ifs.value} !== {8'd23, 8'd59, 8'd59}) begin n_fail++; $display("FAIL casc_preset got=%0d:%0d:%0d exp=23:59:59", ifh.value, ifm.value, ifs.value); end
      ifs.count_up = 1'b1;
      tick();
      ifs.count_up = 1'b0;
      n_tests++; if (ifs.value !== 8'd0 || ifs.carry !== 1'b1 || ifm.value !== 8'd59) begin n_fail++; $display("FAIL casc_sec got=%0d:%0d c=%b exp=59:0 1", ifm.value, ifs.value, ifs.carry); end
      tick();
      n_tests++; if (ifm.value !== 8'd0 || ifm.carry !== 1'b1 || ifh.value !== 8'd23) begin n_fail++; $display("FAIL casc_min got=%0d:%0d c=%b exp=23:0 1", ifh.value, ifm.value, ifm.carry); end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (ifh.carry) hc++;
      end
      n_tests++; if ({ifh.value, ifm.value, ifs.value} !== 24'd0) begin n_fail++; $display("FAIL casc_final got=%0d:%0d:%0d exp=0:0:0", ifh.value, ifm.value, ifs.value); end
      n_tests++; if (hc != 1) begin n_fail++; $display("FAIL casc_hr_carry got=%0d exp=1", hc); end
   endtask

   task automatic test_random();
      int m;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m = 0;
      for (int i = 0; i < 400; i++) begin
         logic cl, ld, hd, up, dn, mh;
         int   lv;
         bit   c, b, e;
         cl = ($urandom_range(15) == 0);
         ld = ($urandom_range(6) == 0);
         hd = ($urandom_range(5) == 0);
         up = 1'($urandom_range(1));
         dn = ($urandom_range(2) == 0);
         mh = 1'($urandom_range(1));
         lv = int'($urandom_range(31));
         if24.clear = cl; if24.load = ld; if24.hold = hd; if24.count_up = up;
         if24.count_dn = dn; if24.mode_12h = mh; if24.load_val = 8'(lv);
         c = 1'b0; b = 1'b0; e = 1'b0;
         if (cl) m = 0;
         else if (ld) begin
            e = (lv >= 24);
            m = e ? 23 : lv;
         end else if (!hd && up && !dn) begin
            c = (m == 23);
            m = (m + 1) % 24;
         end else if (!hd && dn && !up) begin
            b = (m == 0);
            m = (m + 23) % 24;
         end
         tick();
         n_tests++; if (if24.value !== 8'(m)) begin n_fail++; $display("FAIL rnd_value cyc=%0d got=%0d exp=%0d", i, if24.value, m); end
         n_tests++; if ({if24.carry, if24.borrow, if24.load_err} !== {c, b, e}) begin n_fail++; $display("FAIL rnd_pulses cyc=%0d got=%b exp=%b", i, {if24.carry, if24.borrow, if24.load_err}, {c, b, e}); end
         n_tests++; if (if24.disp_bcd !== exp_bcd(m, mh)) begin n_fail++; $display("FAIL rnd_bcd cyc=%0d got=%h exp=%h", i, if24.disp_bcd, exp_bcd(m, mh)); end
         n_tests++; if (if24.pm !== (m >= 12)) begin n_fail++; $display("FAIL rnd_pm cyc=%0d got=%b exp=%b", i, if24.pm, (m >= 12)); end
      end
      if24.clear = 1'b0; if24.load = 1'b0; if24.hold = 1'b0;
      if24.count_up = 1'b0; if24.count_dn = 1'b0; if24.mode_12h = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      if24.clear = 1'b0; if24.hold = 1'b0; if24.load = 1'b0; if24.load_val = '0;
      if24.count_up = 1'b0; if24.count_dn = 1'b0; if24.mode_12h = 1'b0;
      if60.clear = 1'b0; if60.hold = 1'b0; if60.load = 1'b0; if60.load_val = '0;
      if60.count_up = 1'b0; if60.count_dn = 1'b0; if60.mode_12h = 1'b1;
      ifs.clear = 1'b0; ifs.hold = 1'b0; ifs.load = 1'b0; ifs.load_val = '0;
      ifs.count_up = 1'b0; ifs.count_dn = 1'b0; ifs.mode_12h = 1'b0;
      ifm.clear = 1'b0; ifm.hold = 1'b0; ifm.load = 1'b0; ifm.load_val = '0;
      ifm.count_dn = 1'b0; ifm.mode_12h = 1'b0;
      ifh.clear = 1'b0; ifh.hold = 1'b0; ifh.load = 1'b0; ifh.load_val = '0;
      ifh.count_dn = 1'b0; ifh.mode_12h = 1'b1;
      tick();
      test_reset();
      test_count_up();
      test_down_wrap();
      test_priority();
      test_bad_load();
      test_12h();
      test_cascade();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
